// File: rtl/alu_pkt_ctrl.sv
// Byte-stream packet controller: echo, 32-bit add and (optionally) multiply over a UART link.
// Define ALU_CTRL_MUL_EN to enable opcode 0x4D and the external multiplier interface.
module alu_pkt_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    output logic        mul_valid_o,
    input  logic        mul_ready_i,
    input  logic [31:0] mul_result_i,
    input  logic        mul_result_valid_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] OpEcho = 8'hEC;
    localparam logic [7:0] OpAdd  = 8'hAD;
`ifdef ALU_CTRL_MUL_EN
    localparam logic [7:0] OpMul  = 8'h4D;
`endif

    typedef enum logic [3:0] {
        StIdle, StRsv, StLenL, StLenH, StEcho, StLoad, StExec, StResp, StDrain
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      opcode_q, opcode_d;
    logic [7:0]      len_lo_q, len_lo_d;
    logic [15:0]     rem_q, rem_d;
    logic [31:0]     acc_q, acc_d;
    logic [31:0]     opnd_q, opnd_d;
    logic [1:0]      bidx_q, bidx_d;
    logic [1:0]      ridx_q, ridx_d;
    logic            first_q, first_d;
    logic            add_pend_q, add_pend_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [15:0]     len_full, payload;
    logic [31:0]     operand;
    logic            is_arith, timed;
`ifdef ALU_CTRL_MUL_EN
    logic            req_done_q, req_done_d;
    assign is_arith = (opcode_q == OpAdd) || (opcode_q == OpMul);
`else
    logic            unused_mul;
    assign unused_mul = ^{mul_ready_i, mul_result_valid_i, mul_result_i};
    assign is_arith = (opcode_q == OpAdd);
`endif

    assign len_full = {rx_data_i, len_lo_q};
    assign payload  = len_full - 16'd4;
    assign operand  = {rx_data_i, opnd_q[31:8]};
    assign timed    = state_q inside {StRsv, StLenL, StLenH, StEcho, StLoad, StDrain};
    assign busy_o   = (state_q != StIdle);
    assign err_o    = err_q;

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        len_lo_d   = len_lo_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        bidx_d     = bidx_q;
        ridx_d     = ridx_q;
        first_d    = first_q;
        add_pend_d = 1'b0;
        tmo_d      = tmo_q;
        err_d      = 1'b0;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
`ifdef ALU_CTRL_MUL_EN
        req_done_d = req_done_q;
`endif
        rx_ready_o = 1'b1;
        tx_valid_o = tx_valid_q;
        tx_data_o  = tx_data_q;
        // The add of a completed operand lands one cycle after its fourth byte.
        if (add_pend_q) acc_d = acc_q + opnd_q;

        unique case (state_q)
            StIdle: if (rx_valid_i) begin
                opcode_d = rx_data_i;
                state_d  = StRsv;
            end
            StRsv: if (rx_valid_i) state_d = StLenL;
            StLenL: if (rx_valid_i) begin
                len_lo_d = rx_data_i;
                state_d  = StLenH;
            end
            StLenH: if (rx_valid_i) begin
                rem_d      = payload;
                acc_d      = '0;
                opnd_d     = '0;
                bidx_d     = '0;
                ridx_d     = '0;
                first_d    = 1'b1;
                tx_valid_d = 1'b0;
                if (len_full < 16'd4) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (opcode_q == OpEcho) begin
                    state_d = (payload != '0) ? StEcho : StIdle;
                end else if (is_arith && (payload[1:0] == 2'b00)) begin
                    state_d = (payload != '0) ? StLoad : StResp;
                end else begin
                    err_d   = 1'b1;
                    state_d = (payload != '0) ? StDrain : StIdle;
                end
            end
            StEcho: begin
                rx_ready_o = tx_ready_i;
                tx_valid_o = rx_valid_i;
                tx_data_o  = rx_data_i;
                if (rx_valid_i && tx_ready_i) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = StIdle;
                end
            end
            StLoad: if (rx_valid_i) begin
                rem_d  = rem_q - 16'd1;
                bidx_d = bidx_q + 2'd1;
                opnd_d = operand;
                if (bidx_q == 2'd3) begin
                    if (first_q) begin
                        acc_d   = operand;
                        first_d = 1'b0;
                        if (rem_q == 16'd1) state_d = StResp;
                    end else if (opcode_q == OpAdd) begin
                        add_pend_d = 1'b1;
                        if (rem_q == 16'd1) state_d = StResp;
                    end
`ifdef ALU_CTRL_MUL_EN
                    else begin
                        req_done_d = 1'b0;
                        state_d    = StExec;
                    end
`endif
                end
            end
`ifdef ALU_CTRL_MUL_EN
            StExec: begin
                rx_ready_o = 1'b0;
                if (mul_ready_i) req_done_d = 1'b1;
                if ((req_done_q || mul_ready_i) && mul_result_valid_i) begin
                    acc_d   = mul_result_i;
                    state_d = (rem_q == '0) ? StResp : StLoad;
                end
            end
`endif
            StResp: begin
                rx_ready_o = 1'b0;
                if (!tx_valid_q) begin
                    if (!add_pend_q) begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = acc_q[{ridx_q, 3'b000} +: 8];
                    end
                end else if (tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    ridx_d     = ridx_q + 2'd1;
                    if (ridx_q == 2'd3) state_d = StIdle;
                end
            end
            StDrain: if (rx_valid_i) begin
                rem_d = rem_q - 16'd1;
                if (rem_q == 16'd1) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (!timed) begin
            tmo_d = '0;
        end else if (rx_valid_i && rx_ready_o) begin
            tmo_d = '0;
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            err_d      = 1'b1;
            state_d    = StIdle;
            acc_d      = '0;
            opnd_d     = '0;
            add_pend_d = 1'b0;
            tmo_d      = '0;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end
    end

`ifdef ALU_CTRL_MUL_EN
    assign mul_valid_o = (state_q == StExec) && !req_done_q;
    assign mul_a_o     = (state_q == StExec) ? acc_q : '0;
    assign mul_b_o     = (state_q == StExec) ? opnd_q : '0;
`else
    assign mul_valid_o = 1'b0;
    assign mul_a_o     = '0;
    assign mul_b_o     = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            opcode_q   <= '0;
            len_lo_q   <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            bidx_q     <= '0;
            ridx_q     <= '0;
            first_q    <= 1'b0;
            add_pend_q <= 1'b0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
`ifdef ALU_CTRL_MUL_EN
            req_done_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            len_lo_q   <= len_lo_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            bidx_q     <= bidx_d;
            ridx_q     <= ridx_d;
            first_q    <= first_d;
            add_pend_q <= add_pend_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
`ifdef ALU_CTRL_MUL_EN
            req_done_q <= req_done_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_pkt_ctrl.sv
// Self-checking bench for alu_pkt_ctrl: fixed vector table, corner sequences, random packets
// checked against a packet-level reference model.
module tb_alu_pkt_ctrl;

    localparam int unsigned TMO = 50;
`ifdef ALU_CTRL_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic        clk_i, rst_ni;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i, rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o, tx_ready_i;
    logic [31:0] mul_a_o, mul_b_o, mul_result_i;
    logic        mul_valid_o, mul_ready_i, mul_result_valid_i;
    logic        busy_o, err_o;

    alu_pkt_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_valid_o(mul_valid_o),
        .mul_ready_i(mul_ready_i), .mul_result_i(mul_result_i),
        .mul_result_valid_i(mul_result_valid_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct packed {
        logic [127:0] pkt;
        logic [7:0]   plen;
        logic [63:0]  tx;
        logic [7:0]   ntx;
        logic [7:0]   nerr;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0]  pkt_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  exp_tx[$];
    logic [63:0] mul_log[$];
    int          exp_err;
    int          err_cnt = 0;
    bit          tx_toggle = 0;
    int          mul_delay = 3;

    initial begin
        clk_i = 0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        tx_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            tx_ready_i = tx_toggle ? ~tx_ready_i : 1'b1;
        end
    end

    // Sample handshakes mid-cycle; inputs only change just after the rising edge.
    always @(negedge clk_i) begin
        if (tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
        if (err_o) err_cnt++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Behavioural multiplier: grants after mul_delay cycles, answers one cycle later.
    initial begin
        logic [31:0] a, b;
        mul_ready_i = 0;
        mul_result_valid_i = 0;
        mul_result_i = 0;
        forever begin
            @(negedge clk_i);
            if (mul_valid_o) begin
                a = mul_a_o;
                b = mul_b_o;
                mul_log.push_back({a, b});
                for (int i = 0; i < mul_delay; i++) begin
                    @(negedge clk_i);
                    check("mul_hold", {31'b0, mul_valid_o, a ^ mul_a_o, b ^ mul_b_o}, 65'd1 << 64);
                end
                mul_ready_i = 1;
                @(posedge clk_i);
                #1;
                mul_ready_i = 0;
                mul_result_valid_i = 1;
                mul_result_i = a * b;
                @(posedge clk_i);
                #1;
                mul_result_valid_i = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data_i = b;
        rx_valid_i = 1;
        forever begin
            @(negedge clk_i);
            if (rx_ready_o) break;
            n++;
            if (n > 2000) begin
                fail("rx_accept");
                break;
            end
        end
        @(posedge clk_i);
        #1;
        rx_valid_i = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (busy_o && n < 5000);
        if (busy_o) fail("idle");
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_result(input string name);
        check({name, " ntx"}, 64'(tx_q.size()), 64'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
            check($sformatf("%s tx[%0d]", name, i), 64'(tx_q[i]), 64'(exp_tx[i]));
        check({name, " err"}, 64'(err_cnt), 64'(exp_err));
    endtask

    task automatic run_pkt(input string name);
        tx_q.delete();
        err_cnt = 0;
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
        wait_idle();
        check_result(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tx_valid"}, 64'(tx_valid_o), 64'd0);
        check({tag, " tx_data"}, 64'(tx_data_o), 64'd0);
        check({tag, " mul"}, {31'b0, mul_valid_o, mul_a_o | mul_b_o}, 64'd0);
        check({tag, " busy"}, 64'(busy_o), 64'd0);
        check({tag, " err"}, 64'(err_o), 64'd0);
        check({tag, " rx_ready"}, 64'(rx_ready_o), 64'd1);
    endtask

    // Packet-level reference: whole-packet arithmetic, no notion of states or cycles.
    function automatic void model();
        logic [7:0]  op;
        int          len, p;
        logic [31:0] acc, v;
        exp_tx.delete();
        exp_err = 0;
        op  = pkt_q[0];
        len = int'({pkt_q[3], pkt_q[2]});
        p   = len - 4;
        if (len < 4) begin
            exp_err = 1;
        end else if (op == 8'hEC) begin
            for (int i = 0; i < p; i++) exp_tx.push_back(pkt_q[4 + i]);
        end else if ((op == 8'hAD || (MulEn && op == 8'h4D)) && p % 4 == 0) begin
            acc = 0;
            for (int k = 0; k < p / 4; k++) begin
                v = {pkt_q[7 + 4 * k], pkt_q[6 + 4 * k], pkt_q[5 + 4 * k], pkt_q[4 + 4 * k]};
                if (k == 0) acc = v;
                else if (op == 8'hAD) acc = acc + v;
                else acc = acc * v;
            end
            for (int i = 0; i < 4; i++) exp_tx.push_back(acc[8 * i +: 8]);
        end else begin
            exp_err = 1;
        end
    endfunction

    function automatic vec_t mk(input logic [127:0] raw, input int n, input logic [63:0] txr,
                                input int ntx, input int nerr);
        vec_t v;
        v.pkt = raw;
        v.plen = 8'(n);
        v.tx = txr;
        v.ntx = 8'(ntx);
        v.nerr = 8'(nerr);
        return v;
    endfunction

    function automatic void load_pkt(input logic [7:0] b[]);
        pkt_q.delete();
        foreach (b[i]) pkt_q.push_back(b[i]);
    endfunction

    initial begin
        vec_t tbl[11];
        vec_t v;
        int   n, sel, p;
        logic [7:0]  op;
        logic [15:0] lenv;

        rst_ni = 0;
        rx_valid_i = 0;
        rx_data_i = 0;
        repeat (2) @(negedge clk_i);
        check_reset_outputs("reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1;
        repeat (2) @(posedge clk_i);
        #1;

        tbl[0]  = mk(96'hEC_F4_0C_00_48_69_01_02_03_04_05_06, 12, 64'h48_69_01_02_03_04_05_06, 8, 0);
        tbl[1]  = mk(96'hAD_F4_0C_00_DE_AD_BE_EF_1A_98_31_AB, 12, 64'hF8_45_F0_9A, 4, 0);
        tbl[2]  = mk(80'hAD_00_0A_00_11_22_33_44_55_66, 10, 64'h0, 0, 1);
        tbl[3]  = mk(96'h4D_00_0C_00_03_00_00_00_05_00_00_00, 12,
                     MulEn ? 64'h0F_00_00_00 : 64'h0, MulEn ? 4 : 0, MulEn ? 0 : 1);
        tbl[4]  = mk(32'hAD_00_04_00, 4, 64'h00_00_00_00, 4, 0);
        tbl[5]  = mk(32'hEC_00_04_00, 4, 64'h0, 0, 0);
        tbl[6]  = mk(32'h12_34_03_00, 4, 64'h0, 0, 1);
        tbl[7]  = mk(48'h55_00_06_00_AA_BB, 6, 64'h0, 0, 1);
        tbl[8]  = mk(64'hAD_00_08_00_78_56_34_12, 8, 64'h78_56_34_12, 4, 0);
        tbl[9]  = mk(128'hAD_00_10_00_FF_FF_FF_FF_01_00_00_00_02_00_00_00, 16,
                     64'h02_00_00_00, 4, 0);
        tbl[10] = mk(40'hEC_00_05_00_7E, 5, 64'h7E, 1, 0);

        mul_log.delete();
        for (int t = 0; t < 11; t++) begin
            v = tbl[t];
            n = int'(v.plen);
            pkt_q.delete();
            for (int i = 0; i < n; i++) pkt_q.push_back(v.pkt[8 * (n - 1 - i) +: 8]);
            exp_tx.delete();
            for (int i = 0; i < int'(v.ntx); i++)
                exp_tx.push_back(v.tx[8 * (int'(v.ntx) - 1 - i) +: 8]);
            exp_err = int'(v.nerr);
            run_pkt($sformatf("vec%0d", t));
        end
`ifdef ALU_CTRL_MUL_EN
        check("mul_reqs", 64'(mul_log.size()), 64'd1);
        if (mul_log.size() > 0) check("mul_operands", mul_log[0], {32'd3, 32'd5});
`endif

        // Timeout mid-echo, then the next byte must start a fresh packet.
        tx_q.delete();
        err_cnt = 0;
        load_pkt('{8'hEC, 8'h00, 8'h0C, 8'h00, 8'h48});
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
        n = 0;
        forever begin
            @(negedge clk_i);
            n++;
            if (err_o) break;
            if (n > int'(TMO) + 20) begin
                fail("timeout_err");
                break;
            end
        end
        check("timeout_lat_ok", 64'(n >= int'(TMO) && n <= int'(TMO) + 1), 64'd1);
        check("timeout_busy", 64'(busy_o), 64'd0);
        check("timeout_ntx", 64'(tx_q.size()), 64'd1);
        @(posedge clk_i);
        #1;
        load_pkt('{8'hAD, 8'h00, 8'h04, 8'h00});
        model();
        exp_err = 0;
        err_cnt = 0;
        tx_q.delete();
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
        wait_idle();
        check_result("after_timeout");

        // Echo under transmit back-pressure.
        tx_toggle = 1;
        load_pkt('{8'hEC, 8'h01, 8'h0E, 8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5,
                   8'hA6, 8'hA7, 8'hA8, 8'hA9});
        model();
        run_pkt("echo_bp");
        tx_toggle = 0;

        // Reset in the middle of operand loading.
        tx_q.delete();
        err_cnt = 0;
        load_pkt('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22});
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
        rst_ni = 0;
        @(negedge clk_i);
        check_reset_outputs("mid_reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1;
        @(posedge clk_i);
        #1;
        check("mid_reset ntx", 64'(tx_q.size()), 64'd0);
        load_pkt('{8'hAD, 8'hF4, 8'h0C, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h1A, 8'h98,
                   8'h31, 8'hAB});
        model();
        run_pkt("after_reset");

        // Random packets against the reference model.
        for (int r = 0; r < 40; r++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) op = 8'hEC;
            else if (sel < 6) op = 8'hAD;
            else if (sel < 8) op = 8'h4D;
            else op = 8'($urandom_range(0, 255));
            if (op == 8'hEC) p = $urandom_range(0, 10);
            else p = 4 * $urandom_range(0, 3);
            if ($urandom_range(0, 5) == 0) p = p + $urandom_range(1, 3);
            lenv = 16'(p + 4);
            if ($urandom_range(0, 9) == 0) begin
                lenv = 16'($urandom_range(0, 3));
                p = 0;
            end
            pkt_q.delete();
            pkt_q.push_back(op);
            pkt_q.push_back(8'($urandom_range(0, 255)));
            pkt_q.push_back(lenv[7:0]);
            pkt_q.push_back(lenv[15:8]);
            for (int i = 0; i < p; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
            tx_toggle = 1'($urandom_range(0, 1));
            mul_delay = $urandom_range(0, 3);
            model();
            run_pkt($sformatf("rand%0d", r));
        end
        tx_toggle = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_pkt_ctrl.md
ALU_PKT_CTRL -- requirements
Module: alu_pkt_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000: idle cycles allowed between bytes of one packet.
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_ni  input  1  asynchronous, active-low reset.
REQ-004 rx_data_i  input  8  byte from UART receiver.
REQ-005 rx_valid_i / rx_ready_o  input / output  1 / 1  receive handshake; byte consumed when both are high.
REQ-006 tx_data_o  output  8  byte to UART transmitter.
REQ-007 tx_valid_o / tx_ready_i  output / input  1 / 1  transmit handshake; byte sent when both are high.
REQ-008 mul_a_o, mul_b_o  output  32 each  multiplier operands.
REQ-009 mul_valid_o / mul_ready_i  output / input  1 / 1  multiplier request handshake.
REQ-010 mul_result_i / mul_result_valid_i  input  32 / 1  multiplier product, qualified by a one-cycle strobe.
REQ-011 busy_o  output  1  high whenever the state is not IDLE.
REQ-012 err_o  output  1  one-cycle pulse on a protocol error.

Function
REQ-013 Packet format: opcode, reserved, LEN_L, LEN_H, then payload.
  - LEN is the total packet length in bytes, including the 4-byte header, little-endian.
REQ-014 States: IDLE, RSV, LEN_L, LEN_H, ECHO, LOAD, EXEC, RESP, DRAIN.
  - IDLE -> RSV on any byte, storing it as the opcode.
  - RSV ignores its byte.
  - LEN_L and LEN_H capture the length.
REQ-015 After LEN_H, with payload count P = LEN-4:
  - LEN<4: pulse err_o, go to IDLE.
  - Opcode 0xEC: go to ECHO if P>0, else IDLE.
  - Opcode 0xAD (add) or 0x4D (mul), P a multiple of 4: go to LOAD if P>0, else RESP with result 0.
  - Any other case: pulse err_o, go to DRAIN if P>0, else IDLE.
REQ-016 ECHO is a combinational pass-through for exactly P bytes, then IDLE.
  - tx_data_o = rx_data_i; tx_valid_o = rx_valid_i; rx_ready_o = tx_ready_i.
REQ-017 LOAD assembles 32-bit operands LSB-first from 4 consecutive bytes.
  - The first operand loads the 32-bit accumulator.
  - Each later operand: add does acc = acc + operand, modulo 2^32, in the cycle after the 4th byte; mul goes to EXEC.
REQ-018 EXEC drives mul_a_o = acc and mul_b_o = operand, and holds mul_valid_o until mul_ready_i.
  - It then waits for mul_result_valid_i, stores the low 32 bits of the product into acc, and returns to LOAD, or to RESP after the last operand.
  - rx_ready_o is low in EXEC.
REQ-019 After the last operand, go to RESP.
  - RESP sends acc as 4 bytes LSB-first on registered tx_valid_o/tx_data_o, holding each byte until tx_ready_i, then returns to IDLE.
REQ-020 DRAIN accepts and discards P bytes (rx_ready_o=1), then IDLE.
REQ-021 rx_ready_o is 1 in IDLE, RSV, LEN_L, LEN_H, LOAD and DRAIN; it is 0 in RESP and EXEC; it follows REQ-016 in ECHO.
REQ-022 Timeout counter: counts cycles without an accepted rx byte while in RSV, LEN_L, LEN_H, ECHO, LOAD or DRAIN.
  - On reaching TIMEOUT_CYCLES: pulse err_o, clear partial operand and accumulator, go to IDLE.
  - The counter resets on every accepted byte and does not run in EXEC or RESP.
REQ-023 Payload byte counter is 16 bits; LEN=0xFFFF is legal, so no wrap is possible within one packet.
REQ-024 err_o pulses at most once per packet, in the cycle the error is detected.

Reset
REQ-025 When rst_ni is low, the block SHALL enter IDLE asynchronously.
  - Outputs: tx_valid_o=0, tx_data_o=0, mul_valid_o=0, mul_a_o=0, mul_b_o=0, busy_o=0, err_o=0, rx_ready_o=1.
  - Cleared: accumulator, operand register, counters, opcode.
REQ-026 Reset mid-packet SHALL discard the packet; the first byte after reset is treated as an opcode.

Configuration
REQ-027 Macro ALU_CTRL_MUL_EN:
  - Defined: opcode 0x4D is supported per REQ-017/REQ-018.
  - Undefined: 0x4D is an unknown opcode (err_o pulse, DRAIN), the EXEC state and multiplier logic are removed, and the mul_* outputs are tied to 0.

Verification
REQ-028 Echo: EC F4 0C 00 48 69 01 02 03 04 05 06 -> tx 48 69 01 02 03 04 05 06, then IDLE, no err_o.
REQ-029 Add: AD F4 0C 00 DE AD BE EF 1A 98 31 AB -> tx F8 45 F0 9A (0x9AF045F8, carry dropped).
REQ-030 Bad length: AD 00 0A 00 plus 6 bytes -> err_o pulse after LEN_H, 6 bytes drained, no tx, next packet parsed normally.
REQ-031 Mul with macro: 4D 00 0C 00 03 00 00 00 05 00 00 00, mul_ready_i delayed 3 cycles -> mul_a_o=3, mul_b_o=5 held until mul_ready_i; tx 0F 00 00 00.
  - Without macro: err_o pulse, 8 bytes drained, no tx.
REQ-032 Timeout: EC 00 0C 00 48, then stall TIMEOUT_CYCLES -> err_o pulse, IDLE.
  - Next byte AD is taken as an opcode.
REQ-033 Back-pressure and reset: echo with tx_ready_i toggling every cycle -> no byte lost or duplicated.
  - Asserting rst_ni=0 during LOAD -> outputs at reset values, next packet correct.
